elastic_pipe_reg: RTL and testbench
===================================

ELASTIC_PIPE_REG -- requirements
Module: elastic_pipe_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the payload width in bits (legal range 1..256).
REQ-002 The block SHALL have parameter DEPTH, default 2, meaning the number of buffered entries (legal range 2..16, not required to be a power of two).
REQ-003 The block SHALL have parameter BUBBLE, default all-zeros, WIDTH bits, meaning the value driven on out_data when empty.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit, synchronous and active-high.
REQ-006 The block SHALL have port flush, input, 1 bit, a synchronous discard of all held and incoming data.
REQ-007 The block SHALL have port in_valid, input, 1 bit, meaning the upstream payload is present.
REQ-008 The block SHALL have port in_ready, output, 1 bit, meaning the block accepts a payload this cycle.
REQ-009 The block SHALL have port in_data, input, WIDTH bits, the upstream payload.
REQ-010 The block SHALL have port out_valid, output, 1 bit, meaning a payload is presented downstream.
REQ-011 The block SHALL have port out_ready, input, 1 bit, meaning downstream consumes this cycle.
REQ-012 The block SHALL have port out_data, output, WIDTH bits, the oldest held payload.
REQ-013 The block SHALL have port count, output, $clog2(DEPTH+1) bits, the number of entries currently held.

Function
REQ-014 Push SHALL occur when in_valid && in_ready && !flush; pop SHALL occur when out_valid && out_ready && !flush.
REQ-015 in_ready SHALL equal (count < DEPTH) and SHALL be derived from registered state only, with no combinational path from out_ready or in_valid.
REQ-016 out_valid SHALL equal (count != 0); out_data SHALL be the oldest entry when count != 0 and BUBBLE otherwise.
REQ-017 Latency SHALL be exactly 1 cycle: a payload pushed at edge N is visible on out_data after edge N, with no same-cycle pass-through.
REQ-018 Ordering SHALL be strict FIFO, with no duplication or loss except under flush or reset.
REQ-019 Push and pop in the same cycle SHALL leave count unchanged and advance both pointers.
REQ-020 Read and write pointers SHALL wrap from DEPTH-1 to 0, including when DEPTH is not a power of two.
REQ-021 When full (count == DEPTH), in_ready SHALL be 0 even if out_ready is 1 in that cycle; the push is refused and the pop proceeds.
REQ-022 When empty, out_ready SHALL be ignored and count SHALL NOT underflow.
REQ-023 With DEPTH >= 2 and out_ready held at 1, the block SHALL sustain one transfer per cycle.
REQ-024 flush SHALL set count to 0 and both pointers to 0 at the next edge, and SHALL discard any simultaneous push or pop.
REQ-025 With flush asserted, out_valid and in_ready SHALL still reflect pre-edge state during that cycle; upstream SHALL treat the handshake as void.
REQ-026 Storage contents need not be cleared by flush or reset; only pointers and count are state of record.

Reset
REQ-027 When reset is high at a rising edge, count SHALL become 0, both pointers 0, out_valid 0, in_ready 1 and out_data BUBBLE.
REQ-028 reset SHALL dominate flush and any push or pop in the same cycle.
REQ-029 Reset asserted mid-stream SHALL drop all held entries; the first push after deassertion SHALL be the first entry popped.

Structure
REQ-030 A shared package pipe_pkg SHALL hold the RV32I NOP constant (32'h0000_0013), used as BUBBLE for instruction-carrying instances, and the count-width helper function.
REQ-031 A single sub-module wrap_ctr SHALL implement a parametrised modulo-DEPTH pointer with increment enable and synchronous clear, instantiated for both read and write pointers.
REQ-032 Storage SHALL be a register array of DEPTH x WIDTH bits, written on push and read via the read pointer; it SHALL NOT be inferred as a RAM with a read latency.

Verification
REQ-033 Reset, then push in_data = 32'hA, B, C with out_ready = 0 and DEPTH = 2 -> count = 2, in_ready = 0 after the second push, and C is refused.
REQ-034 Continuous in_valid = 1 and out_ready = 1, data 1..100 -> out_data = 1..100 in order, one per cycle, first output one cycle after the first push.
REQ-035 DEPTH = 3 full, then push and pop in the same cycle -> pop occurs, push refused, count = 2; pointers wrap correctly over 10 fill/drain rounds.
REQ-036 Hold 2 entries, assert flush with in_valid = 1 -> next cycle count = 0, out_valid = 0, out_data = BUBBLE (32'h13 in the NOP instance), and the incoming word is never emitted.
REQ-037 Assert reset and flush together mid-stream with 1 entry held -> reset values per REQ-027; then push 32'h55 -> out_data = 32'h55 one cycle later.
REQ-038 Randomised valid/ready for 10k cycles against a scoreboard -> no loss, duplication or reordering, count always within 0..DEPTH.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for elastic pipeline registers:
// the RV32I NOP bubble, the count-width helper and the handshake op encoding.
package pipe_pkg;

   localparam logic [31:0] RV32I_NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      OP_IDLE = 2'b00,
      OP_POP  = 2'b01,
      OP_PUSH = 2'b10,
      OP_BOTH = 2'b11
   } op_e;

   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/elastic_pipe_reg_wrap_ctr.sv
// Modulo-DEPTH pointer with increment enable and synchronous clear.
// Wraps explicitly at DEPTH-1 so non power-of-two depths work.
module wrap_ctr #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned PW    = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          clr_i,
   input  logic          inc_i,
   output logic [PW-1:0] ptr_o
);

   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

   logic [PW-1:0] ptr_q, ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (clr_i) begin
         ptr_d = '0;
      end else if (inc_i) begin
         ptr_d = (ptr_q == LAST) ? '0 : ptr_q + PW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr_o = ptr_q;

endmodule

// File: rtl/elastic_pipe_reg.sv
// Elastic valid/ready pipeline register: DEPTH-entry register FIFO,
// one-cycle latency, ready driven only from registered count.
module elastic_pipe_reg
   import pipe_pkg::*;
#(
   parameter int unsigned      WIDTH  = 32,
   parameter int unsigned      DEPTH  = 2,
   parameter logic [WIDTH-1:0] BUBBLE = '0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [WIDTH-1:0]          in_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [WIDTH-1:0]          out_data,
   output logic [cnt_w(DEPTH)-1:0]   count
);

   localparam int CW = cnt_w(DEPTH);
   localparam int PW = $clog2(DEPTH);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [CW-1:0]    count_q, count_d;
   logic [PW-1:0]    rptr, wptr;
   logic             push, pop;
   op_e              op;

   assign in_ready  = (count_q < FULL);
   assign out_valid = (count_q != '0);
   assign push      = in_valid & in_ready & ~flush;
   assign pop       = out_valid & out_ready & ~flush;
   assign op        = op_e'({push, pop});

   always_comb begin
      count_d = count_q;
      unique case (op)
         OP_PUSH: count_d = count_q + CW'(1);
         OP_POP:  count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      if (flush) begin
         count_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Payload storage is deliberately unreset; count gates visibility.
   always_ff @(posedge clk) begin
      if (push && !reset) begin
         mem_q[wptr] <= in_data;
      end
   end

   wrap_ctr #(.DEPTH(DEPTH), .PW(PW)) u_wptr (
      .clk_i (clk),
      .rst_i (reset),
      .clr_i (flush),
      .inc_i (push),
      .ptr_o (wptr)
   );

   wrap_ctr #(.DEPTH(DEPTH), .PW(PW)) u_rptr (
      .clk_i (clk),
      .rst_i (reset),
      .clr_i (flush),
      .inc_i (pop),
      .ptr_o (rptr)
   );

   assign out_data = out_valid ? mem_q[rptr] : BUBBLE;
   assign count    = count_q;

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Bench for elastic_pipe_reg: a DEPTH=2 NOP-bubble instance and a
// DEPTH=3 zero-bubble instance, each with a queue scoreboard.
module tb_elastic_pipe_reg;
   import pipe_pkg::*;

   localparam int DEP [2] = '{2, 3};
   localparam logic [31:0] BUB [2] = '{RV32I_NOP, 32'h0};

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        flush     [2];
   logic        in_valid  [2];
   logic        in_ready  [2];
   logic [31:0] in_data   [2];
   logic        out_valid [2];
   logic        out_ready [2];
   logic [31:0] out_data  [2];
   logic [1:0]  count     [2];

   int n_chk = 0;
   int n_err = 0;
   bit armed = 1'b0;

   always #5 clk = ~clk;

   elastic_pipe_reg #(
      .WIDTH(32), .DEPTH(2), .BUBBLE(RV32I_NOP)
   ) u_d2 (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush[0]),
      .in_valid  (in_valid[0]),
      .in_ready  (in_ready[0]),
      .in_data   (in_data[0]),
      .out_valid (out_valid[0]),
      .out_ready (out_ready[0]),
      .out_data  (out_data[0]),
      .count     (count[0])
   );

   elastic_pipe_reg #(
      .WIDTH(32), .DEPTH(3)
   ) u_d3 (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush[1]),
      .in_valid  (in_valid[1]),
      .in_ready  (in_ready[1]),
      .in_data   (in_data[1]),
      .out_valid (out_valid[1]),
      .out_ready (out_ready[1]),
      .out_data  (out_data[1]),
      .count     (count[1])
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         if (n_err <= 20)
            $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      for (int g = 0; g < 2; g++) begin
         flush[g]     = 1'b0;
         in_valid[g]  = 1'b0;
         in_data[g]   = '0;
         out_ready[g] = 1'b0;
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_sb
      logic [31:0] q [$];
      int n;
      always @(negedge clk) begin
         n = q.size();
         if (armed) begin
            check($sformatf("rdy%0d", g), 32'(in_ready[g]), 32'(n < DEP[g]));
            check($sformatf("vld%0d", g), 32'(out_valid[g]), 32'(n != 0));
            check($sformatf("cnt%0d", g), 32'(count[g]), 32'(n));
            check($sformatf("rng%0d", g), 32'(count[g] <= 2'(DEP[g])), 32'd1);
            check($sformatf("dat%0d", g), out_data[g],
                  (n != 0) ? q[0] : BUB[g]);
         end
         if (reset || flush[g]) begin
            q.delete();
         end else begin
            if (out_ready[g] && n != 0) void'(q.pop_front());
            if (in_valid[g] && n < DEP[g]) q.push_back(in_data[g]);
         end
      end
   end

   always @(negedge clk) if (reset) armed <= 1'b1;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      check("rst_cnt", 32'(count[0]), 32'd0);
      check("rst_rdy", 32'(in_ready[0]), 32'd1);
      check("rst_dat", out_data[0], RV32I_NOP);

      // Fill DEPTH=2 with A, B; C must be refused.
      in_valid[0] = 1'b1;
      in_data[0] = 32'hA;
      step();
      in_data[0] = 32'hB;
      step();
      check("full_cnt", 32'(count[0]), 32'd2);
      check("full_rdy", 32'(in_ready[0]), 32'd0);
      in_data[0] = 32'hC;
      step();
      check("refuse_cnt", 32'(count[0]), 32'd2);
      check("refuse_dat", out_data[0], 32'hA);
      in_valid[0] = 1'b0;
      out_ready[0] = 1'b1;
      step();
      check("drain_dat", out_data[0], 32'hB);
      step();
      check("drain_vld", 32'(out_valid[0]), 32'd0);

      // Streaming: one transfer per cycle, one cycle latency.
      in_valid[0] = 1'b1;
      for (int i = 1; i <= 100; i++) begin
         in_data[0] = 32'(i);
         step();
         check("stream", out_data[0], 32'(i));
      end
      in_valid[0] = 1'b0;
      step();
      check("stream_end", 32'(out_valid[0]), 32'd0);
      idle();

      // DEPTH=3: full then push+pop, over 10 wrap rounds.
      for (int r = 0; r < 10; r++) begin
         out_ready[1] = 1'b0;
         in_valid[1] = 1'b1;
         for (int k = 0; k < 3; k++) begin
            in_data[1] = 32'(r * 16 + k);
            step();
         end
         check("d3_full", 32'(count[1]), 32'd3);
         check("d3_rdy", 32'(in_ready[1]), 32'd0);
         in_data[1] = 32'hDEAD;
         out_ready[1] = 1'b1;
         step();
         check("d3_pp", 32'(count[1]), 32'd2);
         check("d3_head", out_data[1], 32'(r * 16 + 1));
         in_valid[1] = 1'b0;
         step();
         step();
         check("d3_empty", 32'(count[1]), 32'd0);
      end
      idle();

      // Flush with two held and a simultaneous push.
      in_valid[0] = 1'b1;
      in_data[0] = 32'h11;
      step();
      in_data[0] = 32'h22;
      step();
      flush[0] = 1'b1;
      in_data[0] = 32'hBAD;
      step();
      idle();
      check("fl_cnt", 32'(count[0]), 32'd0);
      check("fl_vld", 32'(out_valid[0]), 32'd0);
      check("fl_dat", out_data[0], RV32I_NOP);
      out_ready[0] = 1'b1;
      step();
      check("fl_void", 32'(out_valid[0]), 32'd0);
      idle();

      // Reset and flush together mid-stream.
      in_valid[0] = 1'b1;
      in_data[0] = 32'h77;
      step();
      reset = 1'b1;
      flush[0] = 1'b1;
      in_data[0] = 32'h99;
      out_ready[0] = 1'b1;
      step();
      reset = 1'b0;
      idle();
      check("rf_cnt", 32'(count[0]), 32'd0);
      check("rf_rdy", 32'(in_ready[0]), 32'd1);
      check("rf_vld", 32'(out_valid[0]), 32'd0);
      check("rf_dat", out_data[0], RV32I_NOP);
      in_valid[0] = 1'b1;
      in_data[0] = 32'h55;
      step();
      in_valid[0] = 1'b0;
      check("rf_push", out_data[0], 32'h55);
      out_ready[0] = 1'b1;
      step();
      idle();

      // Randomised traffic on both instances.
      for (int c = 0; c < 10000; c++) begin
         for (int g = 0; g < 2; g++) begin
            in_valid[g]  = 1'($urandom_range(0, 1));
            out_ready[g] = 1'($urandom_range(0, 1));
            in_data[g]   = $urandom;
            flush[g]     = ($urandom_range(0, 127) == 0);
         end
         step();
      end
      idle();
      out_ready[0] = 1'b1;
      out_ready[1] = 1'b1;
      for (int c = 0; c < 5; c++) step();
      check("end_cnt0", 32'(count[0]), 32'd0);
      check("end_cnt1", 32'(count[1]), 32'd0);
      @(negedge clk);
      #1;

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
